seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential restoring shift-subtract divider; the inverse of the team's shift-add multiplier (64-bit product from 32-bit operands).
- Divides a 2W-bit dividend by a W-bit divisor, one quotient bit per clock.
- Returns a 2W-bit quotient and a W-bit remainder.
- Internally an FSM plus datapath; runs under a start/busy/done handshake.

Parameters:
- W, 32, divisor and remainder width; dividend and quotient are 2W bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset; 0 sampled at a rising clk edge resets the block.
- start  input  1  request; sampled only in IDLE.
- dividend  input  2W  numerator; captured on the accepted start edge.
- divisor  input  W  denominator; captured on the accepted start edge.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; results valid.
- div_by_zero  output  1  set with done when the captured divisor == 0; held until next accepted start.
- quotient  output  2W  result; held until next accepted start.
- remainder  output  W  result; held until next accepted start.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; busy=0; done=0; div_by_zero=0; quotient=0; remainder=0; counter=0. Reset has priority over everything, including mid-operation; any in-flight result is discarded.
- States: IDLE, ITER, DONE.
- IDLE, start=1: latch D=divisor, Q=dividend, R=0 (W+1 bits), cnt=2W; clear div_by_zero.
  - D!=0: go ITER.
  - D==0: go DONE directly.
- IDLE, start=0: stay; outputs hold.
- ITER, each cycle:
  - T={R[W-1:0],Q[2W-1]} (W+1 bits); Q={Q[2W-2:0],0}.
  - If T>={0,D}: R=T-{0,D} and Q[0]=1; else R=T.
  - cnt decrements each cycle; after the 2W-th ITER cycle (cnt reaches 0) go DONE.
  - busy=1 throughout ITER; start is ignored and has no effect on the operation.
- DONE: done=1 for exactly one cycle; quotient=Q and remainder=R[W-1:0] are registered on entry to DONE; go IDLE next edge.
- Divide-by-zero: quotient=all ones (2W'h..F), remainder=dividend[W-1:0], div_by_zero=1.
- Latency, W=32:
  - Start sampled at edge 0.
  - busy high for cycles 1..64.
  - done high in cycle 65, i.e. visible after edge 65.
  - Divide-by-zero: done visible after edge 1, busy never asserted.
- Back-to-back: start may be asserted in the cycle done is high. It is sampled once the block is in IDLE on the following edge, so throughput is one divide per 2W+2 cycles.
- Arithmetic: unsigned only.
  - Invariant: dividend == quotient*divisor + remainder, with remainder < divisor.
  - The comparison uses W+1 bits so T never overflows.
- Outputs are registered; no combinational path from inputs to outputs.
- Operand inputs may change freely after the accepted start edge.

Test Plan:
- dividend=100, divisor=7, start one cycle -> busy cycles 1..64; done pulse in cycle 65; quotient=14, remainder=2, div_by_zero=0.
- dividend=64'hFFFF_FFFF_FFFF_FFFF, divisor=32'hFFFF_FFFF -> quotient=64'h0000_0001_0000_0001, remainder=0.
- dividend=5, divisor=9 -> quotient=0, remainder=5. Also dividend=0, divisor=3 -> quotient=0, remainder=0.
- dividend=64'h1234, divisor=0 -> done one cycle after start, no busy; quotient=64'hFFFF_FFFF_FFFF_FFFF, remainder=32'h1234, div_by_zero=1. The next valid divide clears div_by_zero.
- Start 1000/10 and hold start high with dividend=77 while busy -> start is ignored; quotient=100, remainder=0. Then assert reset=0 at cycle 30 of a new divide -> next edge: busy=0, done=0, quotient=0, remainder=0, IDLE; no done pulse follows.
- Round-trip: 200 random (X,Y) pairs with Y!=0 and X<2^63, dividend=X*Y[...] truncated to 64 bits -> quotient*divisor+remainder==dividend and remainder<divisor for every pair, with back-to-back starts taken in the done cycle.

Source files
------------

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential divider.
// master drives the operands and start; slave is the divider itself.
interface seq_divider_if #(
    parameter int W = 32
);
    logic             start;
    logic [2*W-1:0]   dividend;
    logic [W-1:0]     divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [2*W-1:0]   quotient;
    logic [W-1:0]     remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, with a start/busy/done handshake and registered outputs.
module seq_divider #(
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          reset,
    seq_divider_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(2 * W) + 1;

    state_t           state;
    state_t           state_next;

    logic [W-1:0]     d_reg;
    logic [2*W-1:0]   q_reg;
    logic [W-1:0]     r_reg;
    logic [CW-1:0]    cnt;
    logic             dz_reg;

    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic [2*W-1:0]   quot_q;
    logic [W-1:0]     rem_q;

    logic [W:0]       trial;
    logic [W-1:0]     diff;
    logic             fits;

    // The partial remainder always ends below the divisor, so it fits in W bits;
    // only the shifted trial value needs the extra bit for the compare.
    always_comb begin
        trial = {r_reg, q_reg[2*W-1]};
        fits  = (trial >= {1'b0, d_reg});
        diff  = trial[W-1:0] - d_reg;
    end

    // NOTE: every signal written in always_comb is given a default first so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.divisor == '0) ? DONE : ITER;
                end
            end
            ITER: begin
                if (cnt == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, and the
    // synchronous reset branch comes first so it wins over any in-flight work.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            d_reg  <= '0;
            q_reg  <= '0;
            r_reg  <= '0;
            cnt    <= '0;
            dz_reg <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
        end else begin
            state  <= state_next;
            busy_q <= (state == ITER);
            done_q <= (state == DONE);

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        d_reg <= bus.divisor;
                        cnt   <= CW'(2 * W);
                        dz_q  <= 1'b0;
                        if (bus.divisor == '0) begin
                            q_reg  <= '1;
                            r_reg  <= bus.dividend[W-1:0];
                            dz_reg <= 1'b1;
                        end else begin
                            q_reg  <= bus.dividend;
                            r_reg  <= '0;
                            dz_reg <= 1'b0;
                        end
                    end
                end
                ITER: begin
                    q_reg <= {q_reg[2*W-2:0], fits};
                    r_reg <= fits ? diff : trial[W-1:0];
                    cnt   <= cnt - CW'(1);
                end
                DONE: begin
                    quot_q <= q_reg;
                    rem_q  <= r_reg;
                    dz_q   <= dz_reg;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: scoreboard of expected results, latency,
// divide-by-zero, start-while-busy, mid-operation reset and back-to-back traffic.
module tb_seq_divider;
    localparam int W = 32;

    typedef struct {
        logic [2*W-1:0] dividend;
        logic [W-1:0]   divisor;
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           dz;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    seq_divider_if #(.W(W)) bus ();

    seq_divider #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one request (accepted at the next edge) and records the model's answer.
    task automatic issue(input logic [2*W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.dividend = x;
        e.divisor  = y;
        if (y == '0) begin
            e.q  = '1;
            e.r  = x[W-1:0];
            e.dz = 1'b1;
        end else begin
            e.q  = x / {{W{1'b0}}, y};
            e.r  = W'(x % {{W{1'b0}}, y});
            e.dz = 1'b0;
        end
        sb.push_back(e);
        bus.dividend = x;
        bus.divisor  = y;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Waits for the done pulse; cycles counts edges after the accept edge.
    task automatic wait_done(input int budget, output bit ok, output int cycles, output int busy_cycles);
        ok          = 1'b0;
        cycles      = 0;
        busy_cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", bus.div_by_zero); end
        n_checks++; if (bus.quotient !== '0) begin n_fail++; $display("FAIL reset_quotient: got %h want 0", bus.quotient); end
        n_checks++; if (bus.remainder !== '0) begin n_fail++; $display("FAIL reset_remainder: got %h want 0", bus.remainder); end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_latency;
        exp_t e;
        issue(64'd100, 32'd7);
        for (int k = 1; k <= 2 * W + 2; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.busy !== (k <= 2 * W)) begin
                n_fail++; $display("FAIL latency_busy cycle %0d: got %b want %b", k, bus.busy, (k <= 2 * W));
            end
            n_checks++;
            if (bus.done !== (k == 2 * W + 1)) begin
                n_fail++; $display("FAIL latency_done cycle %0d: got %b want %b", k, bus.done, (k == 2 * W + 1));
            end
            if (k == 2 * W + 1) begin
                e = sb.pop_front();
                n_checks++; if (bus.quotient !== e.q) begin n_fail++; $display("FAIL basic_quotient: got %0d want %0d", bus.quotient, e.q); end
                n_checks++; if (bus.remainder !== e.r) begin n_fail++; $display("FAIL basic_remainder: got %0d want %0d", bus.remainder, e.r); end
                n_checks++; if (bus.div_by_zero !== e.dz) begin n_fail++; $display("FAIL basic_dz: got %b want %b", bus.div_by_zero, e.dz); end
            end
        end
        n_checks++; if (bus.quotient !== 64'd14) begin n_fail++; $display("FAIL basic_quotient_hold: got %0d want 14", bus.quotient); end
    endtask

    task automatic test_boundaries;
        exp_t e;
        bit   ok;
        int   cyc;
        int   bcyc;
        logic [2*W-1:0] xs[3];
        logic [W-1:0]   ys[3];
        xs[0] = '1;      ys[0] = '1;
        xs[1] = 64'd5;   ys[1] = 32'd9;
        xs[2] = 64'd0;   ys[2] = 32'd3;
        for (int i = 0; i < 3; i++) begin
            issue(xs[i], ys[i]);
            wait_done(200, ok, cyc, bcyc);
            e = sb.pop_front();
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL boundary_%0d_timeout: no done within 200 cycles", i);
            end else begin
                if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dz) begin
                    n_fail++;
                    $display("FAIL boundary_%0d: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                             i, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dz);
                end
            end
        end
        n_checks++;
        if (bus.quotient !== 64'd0 || bus.remainder !== 32'd0) begin
            n_fail++; $display("FAIL zero_dividend: got q=%h r=%h want 0 0", bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_div_by_zero;
        exp_t e;
        bit   ok;
        int   cyc;
        int   bcyc;
        @(posedge clk);
        #1;
        issue(64'h1234, 32'd0);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL dz_done_latency: got %b want 1", bus.done); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL dz_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.quotient !== e.q) begin n_fail++; $display("FAIL dz_quotient: got %h want %h", bus.quotient, e.q); end
        n_checks++; if (bus.remainder !== e.r) begin n_fail++; $display("FAIL dz_remainder: got %h want %h", bus.remainder, e.r); end
        n_checks++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", bus.div_by_zero); end
        @(posedge clk);
        #1;
        n_checks++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag_hold: got %b want 1", bus.div_by_zero); end
        issue(64'd50, 32'd5);
        n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_clear_on_start: got %b want 0", bus.div_by_zero); end
        wait_done(200, ok, cyc, bcyc);
        e = sb.pop_front();
        n_checks++;
        if (!ok || bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL dz_followup: ok=%b got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=0",
                     ok, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r);
        end
    endtask

    task automatic test_start_ignored;
        exp_t e;
        bit   ok;
        int   cyc;
        int   bcyc;
        issue(64'd1000, 32'd10);
        bus.start    = 1'b1;
        bus.dividend = 64'd77;
        bus.divisor  = 32'd1;
        wait_done(200, ok, cyc, bcyc);
        bus.start = 1'b0;
        e = sb.pop_front();
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ignore_timeout: no done within 200 cycles"); end
        n_checks++; if (bus.quotient !== e.q) begin n_fail++; $display("FAIL ignore_quotient: got %0d want %0d", bus.quotient, e.q); end
        n_checks++; if (bus.remainder !== e.r) begin n_fail++; $display("FAIL ignore_remainder: got %0d want %0d", bus.remainder, e.r); end
        n_checks++; if (bcyc != 2 * W) begin n_fail++; $display("FAIL ignore_busy_len: got %0d want %0d", bcyc, 2 * W); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop;
        bit ok;
        int cyc;
        int bcyc;
        issue(64'd500, 32'd3);
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        void'(sb.pop_back());
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b want 0", bus.done); end
        n_checks++; if (bus.quotient !== '0) begin n_fail++; $display("FAIL midreset_quotient: got %h want 0", bus.quotient); end
        n_checks++; if (bus.remainder !== '0) begin n_fail++; $display("FAIL midreset_remainder: got %h want 0", bus.remainder); end
        reset = 1'b1;
        wait_done(100, ok, cyc, bcyc);
        n_checks++; if (ok) begin n_fail++; $display("FAIL midreset_spurious_done: got done at cycle %0d want none", cyc); end
        n_checks++; if (bcyc != 0) begin n_fail++; $display("FAIL midreset_busy_after: got %0d busy cycles want 0", bcyc); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        bit   ok;
        int   cyc;
        int   bcyc;
        logic [2*W-1:0] x;
        logic [W-1:0]   y;
        logic [2*W-1:0] recon;
        for (int i = 0; i < 200; i++) begin
            x = {1'b0, 31'($urandom), 32'($urandom)};
            y = W'($urandom);
            if (y == '0) y = 32'd1;
            if (i > 0) begin
                wait_done(200, ok, cyc, bcyc);
                e = sb.pop_front();
                n_checks++;
                if (!ok) begin
                    n_fail++; $display("FAIL b2b_%0d_timeout: no done within 200 cycles", i);
                    break;
                end
                recon = bus.quotient * {{W{1'b0}}, e.divisor} + {{W{1'b0}}, bus.remainder};
                if (bus.quotient !== e.q || bus.remainder !== e.r || recon !== e.dividend ||
                    bus.remainder >= e.divisor || cyc != 2 * W + 1) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
                             i, bus.quotient, bus.remainder, cyc, e.q, e.r, 2 * W + 1);
                end
            end
            issue(64'(x * {{W{1'b0}}, y}), y);
        end
        wait_done(200, ok, cyc, bcyc);
        e = sb.pop_front();
        n_checks++;
        if (!ok || bus.quotient !== e.q || bus.remainder !== e.r) begin
            n_fail++; $display("FAIL b2b_last: ok=%b got q=%h r=%h want q=%h r=%h", ok, bus.quotient, bus.remainder, e.q, e.r);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_latency();
        test_boundaries();
        test_div_by_zero();
        test_start_ignored();
        test_reset_midop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
